// File: rtl/block_retire_collector.sv
// Compresses the committed-instruction itype stream into E-Trace instruction
// blocks and hands them to the encoder through a single valid/ready output register.
module block_retire_collector #(
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic [2:0]             itype_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic                   compressed_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [XLEN-1:0]        iaddr_o,
  output logic [IRETIRE_LEN-1:0] iretire_o,
  output logic [2:0]             itype_o,
  output logic                   ilastsize_o,
  output logic                   lost_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, OPEN = 1'b1} state_t;

  localparam logic [IRETIRE_LEN:0] CNT_MAX = {1'b0, {IRETIRE_LEN{1'b1}}};

  state_t                 state_q, next_state;
  logic [XLEN-1:0]        start_q, next_start;
  logic [IRETIRE_LEN-1:0] cnt_q, next_cnt;
  logic                   lastsz_q, next_last;

  logic [IRETIRE_LEN:0]   sz, base, sum;
  logic [2:0]             itype_eff;
  logic                   emit, load, drop;
  logic [XLEN-1:0]        emit_iaddr;
  logic [IRETIRE_LEN-1:0] emit_iretire;
  logic [2:0]             emit_itype;
  logic                   emit_ilast;

  // Next block state and the block (if any) emitted by this cycle's instruction.
  always_comb begin
    sz           = (IRETIRE_LEN+1)'(compressed_i ? 2'd1 : 2'd2);
    base         = (state_q == OPEN) ? {1'b0, cnt_q} : '0;
    sum          = base + sz;
    itype_eff    = (itype_i == 3'd7) ? 3'd6 : itype_i;
    emit         = 1'b0;
    emit_iaddr   = (state_q == OPEN) ? start_q : pc_i;
    emit_iretire = '0;
    emit_itype   = itype_eff;
    emit_ilast   = 1'b0;
    next_state   = state_q;
    next_start   = start_q;
    next_cnt     = cnt_q;
    next_last    = lastsz_q;
    if (valid_i) begin
      case (itype_eff)
        3'd0: begin
          // A full counter flushes the open block and restarts with this instruction.
          if ((state_q == OPEN) && (sum > CNT_MAX)) begin
            emit         = 1'b1;
            emit_iretire = cnt_q;
            emit_ilast   = lastsz_q;
            next_start   = pc_i;
            next_cnt     = sz[IRETIRE_LEN-1:0];
            next_last    = ~compressed_i;
          end else begin
            next_state   = OPEN;
            next_start   = (state_q == OPEN) ? start_q : pc_i;
            next_cnt     = sum[IRETIRE_LEN-1:0];
            next_last    = ~compressed_i;
          end
        end
        3'd1, 3'd2: begin
          emit         = 1'b1;
          emit_iretire = base[IRETIRE_LEN-1:0];
          emit_ilast   = (state_q == OPEN) ? lastsz_q : 1'b0;
          next_state   = IDLE;
          next_cnt     = '0;
          next_last    = 1'b0;
        end
        3'd3, 3'd4, 3'd5, 3'd6: begin
          emit         = 1'b1;
          emit_iretire = sum[IRETIRE_LEN-1:0];
          emit_ilast   = ~compressed_i;
          next_state   = IDLE;
          next_cnt     = '0;
          next_last    = 1'b0;
        end
        default: begin
          emit       = 1'b0;
        end
      endcase
    end else begin
      emit = 1'b0;
    end
    load = emit & (~valid_o | ready_i);
    drop = emit & valid_o & ~ready_i;
  end

  // Block state machine and the output register with its drop flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      start_q     <= '0;
      cnt_q       <= '0;
      lastsz_q    <= 1'b0;
      valid_o     <= 1'b0;
      iaddr_o     <= '0;
      iretire_o   <= '0;
      itype_o     <= 3'd0;
      ilastsize_o <= 1'b0;
      lost_o      <= 1'b0;
    end else begin
      state_q  <= next_state;
      start_q  <= next_start;
      cnt_q    <= next_cnt;
      lastsz_q <= next_last;
      lost_o   <= drop;
      if (load) begin
        valid_o     <= 1'b1;
        iaddr_o     <= emit_iaddr;
        iretire_o   <= emit_iretire;
        itype_o     <= emit_itype;
        ilastsize_o <= emit_ilast;
      end else if (ready_i) begin
        valid_o     <= 1'b0;
      end else begin
        valid_o     <= valid_o;
      end
    end
  end

endmodule
